// File: rtl/id_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_stage_pkg
// Shared decode constants for the instruction-decode stage: MIPS opcode
// values, register-file geometry and the immediate-extension helper.
// No ports (package). Imported by id_stage and id_stage_regfile.
// ---------------------------------------------------------------------------
package id_stage_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int NUM_REGS = 32;

    localparam logic [5:0] OP_R_FORM = 6'b000000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    // Logical immediates are zero-extended; everything else sign-extends.
    function automatic logic [DATA_W-1:0] extend_imm(input logic [5:0] opcode,
                                                     input logic [15:0] imm);
        if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
            return {16'h0000, imm};
        return {{16{imm[15]}}, imm};
    endfunction

    // J and JAL carry a jump target in the rs/rt fields, not register indices.
    function automatic logic is_jump(input logic [5:0] opcode);
        return (opcode == OP_J) || (opcode == OP_JAL);
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// ---------------------------------------------------------------------------
// id_stage_regfile
// 32 x 32-bit general purpose register file with two asynchronous read
// ports and one synchronous write port. Register 0 always reads zero and
// ignores writes. Synchronous active-high reset clears every register.
//
// Optional feature macro: ID_WB_BYPASS_EN
//   defined   -> a read of the register being written this cycle returns
//                the write data (write-through bypass)
//   undefined -> such a read returns the value stored before the write
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wen, waddr, wdata write port
//   raddr1, rdata1    read port 1 (combinational)
//   raddr2, rdata2    read port 2 (combinational)
// ---------------------------------------------------------------------------
module id_stage_regfile
    import id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wen,
    input  logic [REG_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_W-1:0]  raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic [REG_W-1:0]  raddr2,
    output logic [DATA_W-1:0] rdata2
);

    logic [DATA_W-1:0] gpr [NUM_REGS];

    // Storage: reset wipes the whole array, otherwise one write per cycle
    // to any register except $0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++)
                gpr[i] <= '0;
        end else if (wen && waddr != '0) begin
            gpr[waddr] <= wdata;
        end
    end

    // Read ports: $0 is forced to zero; with the bypass build a same-cycle
    // write to the addressed register is forwarded straight through.
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : gpr[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : gpr[raddr2];
`ifdef ID_WB_BYPASS_EN
        if (wen && waddr != '0 && waddr == raddr1)
            rdata1 = wdata;
        if (wen && waddr != '0 && waddr == raddr2)
            rdata2 = wdata;
`else
`endif
    end

endmodule

// File: rtl/id_stage.sv
// ---------------------------------------------------------------------------
// id_stage
// Instruction-decode pipeline stage. Accepts a fetched instruction over a
// valid/ready handshake, reads two GPRs, extends the immediate and presents
// a registered bundle to EX over a second valid/ready handshake. A load-use
// hazard against the most recently accepted LW holds the consumer back for
// LU_BUBBLES empty output cycles.
//
// Optional feature macro: ID_WB_BYPASS_EN (applied inside the register file)
//
// Parameter:
//   LU_BUBBLES  bubble cycles on a load-use hazard (1..3)
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   InValid/InReady             fetch-side handshake
//   InIns, InNextPC             fetched instruction and its PC+4
//   Wen, Wreg, Wdata            writeback port into the register file
//   OutValid/OutReady           EX-side handshake
//   Ins, Rdata1, Rdata2, Ed32,  registered decoded bundle
//   nextPC
// ---------------------------------------------------------------------------
module id_stage
    import id_stage_pkg::*;
#(
    parameter int LU_BUBBLES = 1
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] InIns,
    input  logic [DATA_W-1:0] InNextPC,
    input  logic              Wen,
    input  logic [REG_W-1:0]  Wreg,
    input  logic [DATA_W-1:0] Wdata,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] Ins,
    output logic [DATA_W-1:0] Rdata1,
    output logic [DATA_W-1:0] Rdata2,
    output logic [DATA_W-1:0] Ed32,
    output logic [DATA_W-1:0] nextPC
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [1:0] LAST_BUBBLE = 2'(LU_BUBBLES - 1);

    state_t            state;
    logic [1:0]        bubble_cnt;
    logic [REG_W-1:0]  lw_dest;

    logic [5:0]        in_opcode;
    logic [REG_W-1:0]  in_rs;
    logic [REG_W-1:0]  in_rt;
    logic              out_free;
    logic              hazard;
    logic              stall_done;
    logic              in_fire;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;

    assign in_opcode = InIns[31:26];
    assign in_rs     = InIns[25:21];
    assign in_rt     = InIns[20:16];

    id_stage_regfile regfile (
        .clk    (CLK),
        .rst    (RST),
        .wen    (Wen),
        .waddr  (Wreg),
        .wdata  (Wdata),
        .raddr1 (in_rs),
        .rdata1 (rf_rdata1),
        .raddr2 (in_rt),
        .rdata2 (rf_rdata2)
    );

    // Handshake and hazard decode. The final STALL cycle already releases
    // the consumer so that the gap seen by EX is exactly LU_BUBBLES empty
    // cycles; a hazard in RUN blocks acceptance so the instruction stays
    // pending upstream.
    always_comb begin
        out_free   = !OutValid || OutReady;
        hazard     = InValid && (lw_dest != '0) && !is_jump(in_opcode) &&
                     ((in_rs == lw_dest) || (in_rt == lw_dest));
        stall_done = (state == STALL) && (bubble_cnt == LAST_BUBBLE);
        InReady    = !RST && out_free &&
                     (((state == RUN) && !hazard) || stall_done);
        in_fire    = InValid && InReady;
    end

    // Control FSM plus load-use tracker. A stall only starts once the LW
    // bundle can leave (or already has), so every counted cycle is empty.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= RUN;
            bubble_cnt <= '0;
            lw_dest    <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard && out_free) begin
                        state      <= STALL;
                        bubble_cnt <= '0;
                    end
                end
                STALL: begin
                    if (stall_done) begin
                        state      <= RUN;
                        bubble_cnt <= '0;
                    end else begin
                        bubble_cnt <= bubble_cnt + 2'd1;
                    end
                end
                default: begin
                    state      <= RUN;
                    bubble_cnt <= '0;
                end
            endcase

            if (in_fire)
                lw_dest <= (in_opcode == OP_LW) ? in_rt : '0;
            else if (stall_done)
                lw_dest <= '0;
        end
    end

    // Output bundle: load on acceptance, drop valid when EX takes it with
    // nothing new behind it, otherwise hold everything stable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            OutValid <= 1'b0;
            Ins      <= '0;
            Rdata1   <= '0;
            Rdata2   <= '0;
            Ed32     <= '0;
            nextPC   <= '0;
        end else if (in_fire) begin
            OutValid <= 1'b1;
            Ins      <= InIns;
            Rdata1   <= rf_rdata1;
            Rdata2   <= rf_rdata2;
            Ed32     <= extend_imm(in_opcode, InIns[15:0]);
            nextPC   <= InNextPC;
        end else if (OutReady) begin
            OutValid <= 1'b0;
        end
    end

endmodule
